text_lcd_sink: RTL

TEXT_LCD_SINK -- requirements
Module: text_lcd_sink

---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_ac_step.sv | 12 +
 rtl/text_lcd_sink.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780-style opcodes, DDRAM line limits and cell helpers shared by the text LCD sink.
package lcd_pkg;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE0_LAST = 7'h27;
  localparam logic [6:0] LINE1_LAST = 7'h67;
  localparam logic [7:0] BLANK = 8'h20;

  // Only the first 16 columns of each 40-column DDRAM line are shown.
  function automatic logic visible(input logic [6:0] ac);
    return (ac & 7'h70) == LINE0_BASE || (ac & 7'h70) == LINE1_BASE;
  endfunction

  function automatic logic [4:0] cell_idx(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction
endpackage

// File: rtl/lcd_ac_step.sv
// lcd_ac_step: address counter +/-1 with the two-line DDRAM wrap (0x27<->0x40, 0x67<->0x00).
module lcd_ac_step
  import lcd_pkg::*;
(
  input  logic [6:0] ac_i,
  input  logic       inc_i,
  output logic [6:0] ac_o
);
  always_comb
    ac_o = inc_i ? (ac_i == LINE0_LAST ? LINE1_BASE : ac_i == LINE1_LAST ? LINE0_BASE : ac_i + 7'd1)
                 : (ac_i == LINE0_BASE ? LINE1_LAST : ac_i == LINE1_BASE ? LINE0_LAST : ac_i - 7'd1);
endmodule

// File: rtl/text_lcd_sink.sv
// text_lcd_sink: emulates a 2x16 character LCD on the writer's bus and exposes the visible text.
// Define TEXT_LCD_SINK_READ_EN to enable busy/AC and data reads.
module text_lcd_sink
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES     = 40,
  parameter int CLR_BUSY_CYCLES = 1600
) (
  input  logic         LCDCLK,
  input  logic         PRESETn,
  input  logic         LCD_EN,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [7:0]   LCD_DATA,
  output logic [7:0]   LCD_DATA_OUT,
  output logic         LCD_DATA_OE,
  output logic [255:0] frame,
  output logic         display_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         busy,
  output logic [6:0]   addr_cnt,
  output logic         wr_pulse,
  output logic         cmd_overrun
);
  localparam int MAXC = BUSY_CYCLES > CLR_BUSY_CYCLES ? BUSY_CYCLES : CLR_BUSY_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic          en_q, rs_q, rw_q, id_q, id_d, d_q, d_d, c_q, c_d, b_q, b_d;
  logic          cg_q, cg_d, pulse_q, ovr_q, ovr_d;
  logic [7:0]    data_q;
  logic [6:0]    ac_q, ac_d, ac_step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cells_q [32];
  logic [7:0]    cells_d [32];
  logic          fall, wr, acc, is_shift;

  assign fall     = en_q & ~LCD_EN;
  assign busy     = cnt_q != '0;
  assign wr       = fall & ~rw_q;
  assign acc      = wr & ~busy;
  assign is_shift = ~rs_q && data_q >= OP_SHIFT && data_q < OP_FUNC;

  // One stepper serves data writes, reads (I/D) and cursor shifts (R/L).
  lcd_ac_step u_step (.ac_i(ac_q), .inc_i(is_shift ? data_q[2] : id_q), .ac_o(ac_step));

  always_comb begin
    cells_d = cells_q;
    ac_d    = ac_q;
    id_d    = id_q;
    {d_d, c_d, b_d} = {d_q, c_q, b_q};
    cg_d    = cg_q;
    cnt_d   = busy ? cnt_q - 1'b1 : cnt_q;
    ovr_d   = ovr_q | (wr & busy);
    if (acc) begin
      cnt_d = CW'(BUSY_CYCLES);
      if (rs_q) begin
        if (!cg_q && visible(ac_q)) cells_d[cell_idx(ac_q)] = data_q;
        ac_d = ac_step;
      end else if (data_q >= OP_DDRAM) begin
        ac_d = data_q[6:0];
        cg_d = 1'b0;
      end else if (data_q >= OP_CGRAM) cg_d = 1'b1;
      else if (is_shift) ac_d = data_q[3] ? ac_q : ac_step;
      else if (data_q >= OP_DISP && data_q < OP_SHIFT) {d_d, c_d, b_d} = data_q[2:0];
      else if (data_q >= OP_ENTRY && data_q < OP_DISP) id_d = data_q[1];
      else if (data_q >= OP_HOME && data_q < OP_ENTRY) begin
        ac_d  = LINE0_BASE;
        cnt_d = CW'(CLR_BUSY_CYCLES);
      end else if (data_q == OP_CLEAR) begin
        cells_d = '{default: BLANK};
        ac_d    = LINE0_BASE;
        id_d    = 1'b1;
        cnt_d   = CW'(CLR_BUSY_CYCLES);
      end
    end
`ifdef TEXT_LCD_SINK_READ_EN
    else if (fall && rw_q && rs_q) ac_d = ac_step;
`endif
  end

  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      cells_q <= '{default: BLANK};
      ac_q    <= '0;
      id_q    <= 1'b1;
      {d_q, c_q, b_q} <= '0;
      cg_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      en_q <= LCD_EN;
      if (LCD_EN) {rs_q, rw_q, data_q} <= {LCD_RS, LCD_RW, LCD_DATA};
      cells_q <= cells_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      {d_q, c_q, b_q} <= {d_d, c_d, b_d};
      cg_q    <= cg_d;
      cnt_q   <= cnt_d;
      pulse_q <= acc;
      ovr_q   <= ovr_d;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_frame
    assign frame[8*(31-i) +: 8] = cells_q[i];
  end

  assign {display_on, cursor_on, blink_on} = {d_q, c_q, b_q};
  assign addr_cnt    = ac_q;
  assign wr_pulse    = pulse_q;
  assign cmd_overrun = ovr_q;
`ifdef TEXT_LCD_SINK_READ_EN
  assign LCD_DATA_OE  = LCD_EN & LCD_RW;
  assign LCD_DATA_OUT = LCD_RS ? (visible(ac_q) ? cells_q[cell_idx(ac_q)] : BLANK) : {busy, ac_q};
`else
  assign LCD_DATA_OE  = 1'b0;
  assign LCD_DATA_OUT = '0;
`endif
endmodule
